// File: rtl/io_tdm_port.sv
// io_tdm_port: TDM master moving converter samples between the serial bus and the io RAM.
// Defining IO_TDM_LOOPBACK_EN adds a loopback input that feeds the receiver from sdout.

module io_tdm_port #(
    parameter int IO_WIDTH     = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int IN_BASE      = 0,
    parameter int OUT_BASE     = 256,
    parameter int BCLK_DIV     = 4,
    parameter int RD_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
`ifdef IO_TDM_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic [ADDR_WIDTH-1:0] io_rd_addr,
    output logic                  io_rd_en,
    input  logic [IO_WIDTH-1:0]   io_rd_data,
    output logic [ADDR_WIDTH-1:0] io_wr_addr,
    output logic                  io_wr_en,
    output logic [IO_WIDTH-1:0]   io_wr_data,
    output logic                  bclk,
    output logic                  fsync,
    output logic                  sdout,
    input  logic                  sdin,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int BIT_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  HALF_M1   = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0]  IOB_LAST  = BIT_W'(IO_WIDTH - 1);
    localparam logic [BIT_W:0]    IO_LIM    = (BIT_W + 1)'(IO_WIDTH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic [SLOT_W-1:0]     r_slot;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [IO_WIDTH-1:0]   r_tx_hold;
    logic [IO_WIDTH-1:0]   r_tx_shift;
    logic [IO_WIDTH-1:0]   r_rx_shift;
    logic                  r_wr_last;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [IO_WIDTH-1:0]   r_wr_data;
    logic                  r_bclk;
    logic                  r_fsync;
    logic                  r_sdout;
    logic                  r_done;

    logic                  w_cap;
    logic [IO_WIDTH-1:0]   w_hold_next;
    logic                  w_fall_run;
    logic                  w_rise;
    logic                  w_wrap;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_fall;
    logic [BIT_W-1:0]      w_nbit;
    logic [SLOT_W-1:0]     w_nslot;
    logic [SLOT_W-1:0]     w_pf_slot;
    logic                  w_rx_bit;
    logic                  w_busy;
    logic                  w_prime_issue;

    assign w_cap       = r_rd_pipe[RD_LATENCY-1];
    // Bypass lets a capture and the slot-start load land on the same clk.
    assign w_hold_next = w_cap ? io_rd_data : r_tx_hold;
    assign w_fall_run  = (r_state == S_RUN) && (r_div == DIV_LAST);
    assign w_rise      = (r_state == S_RUN) && (r_div == HALF_M1);
    assign w_wrap      = w_fall_run && (r_bit == BIT_LAST) && (r_slot == SLOT_LAST);
    assign w_start     = (r_state == S_PRIME) && w_cap;
    assign w_stop      = w_wrap && !run;
    assign w_fall      = w_start || (w_fall_run && !w_stop);

    always_comb begin
        w_nbit  = '0;
        w_nslot = '0;
        if (!w_start) begin
            if (r_bit == BIT_LAST) begin
                w_nbit  = '0;
                w_nslot = (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
            end else begin
                w_nbit  = r_bit + BIT_W'(1);
                w_nslot = r_slot;
            end
        end
    end

    assign w_pf_slot = (w_nslot == SLOT_LAST) ? '0 : w_nslot + SLOT_W'(1);

`ifdef IO_TDM_LOOPBACK_EN
    logic r_lb;
    assign w_rx_bit = r_lb ? r_sdout : sdin;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lb <= 1'b0;
        end else if (w_fall && (w_nbit == '0)) begin
            r_lb <= loopback;
        end
    end
`else
    assign w_rx_bit = sdin;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (run)    w_state_next = S_PRIME;
            S_PRIME: if (w_cap)  w_state_next = S_RUN;
            S_RUN:   if (w_stop) w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = (r_state != S_IDLE);
        w_prime_issue = (r_state == S_IDLE) && run;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_slot     <= '0;
            r_rd_pipe  <= '0;
            r_tx_hold  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_wr_last  <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_bclk     <= 1'b0;
            r_fsync    <= 1'b0;
            r_sdout    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_done       <= r_wr_en && r_wr_last;
            r_rd_pipe[0] <= r_rd_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (w_cap) begin
                r_tx_hold <= io_rd_data;
            end

            if (w_prime_issue) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= ADDR_WIDTH'(OUT_BASE);
            end

            if (r_state == S_RUN) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
            end

            if (w_stop) begin
                r_bit   <= '0;
                r_slot  <= '0;
                r_bclk  <= 1'b0;
                r_fsync <= 1'b0;
                r_sdout <= 1'b0;
            end else if (w_fall) begin
                r_bit   <= w_nbit;
                r_slot  <= w_nslot;
                r_bclk  <= 1'b0;
                r_fsync <= (w_nbit == '0) && (w_nslot == '0);
                if (w_nbit == '0) begin
                    r_sdout    <= w_hold_next[IO_WIDTH-1];
                    r_tx_shift <= w_hold_next << 1;
                end else if ({1'b0, w_nbit} < IO_LIM) begin
                    r_sdout    <= r_tx_shift[IO_WIDTH-1];
                    r_tx_shift <= r_tx_shift << 1;
                end else begin
                    r_sdout <= 1'b0;
                end
                // Last bit of slot k fetches the sample for slot k+1.
                if (w_nbit == BIT_LAST) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(w_pf_slot);
                end
            end else if (w_rise) begin
                r_bclk <= 1'b1;
                if ({1'b0, r_bit} < IO_LIM) begin
                    r_rx_shift <= {r_rx_shift[IO_WIDTH-2:0], w_rx_bit};
                    if (r_bit == IOB_LAST) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_WIDTH'(IN_BASE) + ADDR_WIDTH'(r_slot);
                        r_wr_data <= {r_rx_shift[IO_WIDTH-2:0], w_rx_bit};
                        r_wr_last <= (r_slot == SLOT_LAST);
                    end
                end
            end
        end
    end

    assign io_rd_addr = r_rd_addr;
    assign io_rd_en   = r_rd_en;
    assign io_wr_addr = r_wr_addr;
    assign io_wr_en   = r_wr_en;
    assign io_wr_data = r_wr_data;
    assign bclk       = r_bclk;
    assign fsync      = r_fsync;
    assign sdout      = r_sdout;
    assign frame_done = r_done;
    assign busy       = w_busy;

endmodule
